// File: rtl/hazard_halt_control.sv
// Halt/flush arbiter feeding the IFU: merges load-use, mul/div, branch-flush and
// debug halt/resume into one registered halt level, a flush strobe and a cause code.
module hazard_halt_control #(
    parameter int MD_CYCLES    = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input  logic        hctl_clock_in,
    input  logic        hctl_reset_in,
    input  logic        load_use_in,
    input  logic        md_start_in,
    input  logic        branch_taken_in,
    input  logic        dbg_halt_req_in,
    input  logic        dbg_resume_in,
    output logic        halt_signal_out,
    output logic        flush_out,
    output logic        dbg_halted_out,
    output logic [2:0]  stall_cause_out,
    output logic [15:0] stall_count_out
);

    // Encoding matches the cause code driven while in each state.
    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_STALL_LU  = 3'd1,
        S_STALL_MD  = 3'd2,
        S_FLUSH     = 3'd3,
        S_DBG_DRAIN = 3'd4,
        S_DBG_HALT  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             halt_q, flush_q, dbg_q;
    logic [2:0]       cause_q;
    logic [15:0]      count_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_RUN: begin
                pend_d = 1'b0;
                if (dbg_halt_req_in) begin
                    state_d = S_DBG_HALT;
                end else if (branch_taken_in) begin
                    state_d = S_FLUSH;
                    cnt_d   = FL_LOAD;
                end else if (md_start_in) begin
                    state_d = S_STALL_MD;
                    cnt_d   = MD_LOAD;
                end else if (load_use_in) begin
                    state_d = S_STALL_LU;
                end
            end
            S_STALL_LU: begin
                state_d = dbg_halt_req_in ? S_DBG_HALT : S_RUN;
            end
            S_STALL_MD, S_DBG_DRAIN: begin
                // A debug request never shortens the mul/div countdown.
                if (cnt_q == '0) begin
                    state_d = (dbg_halt_req_in || state_q == S_DBG_DRAIN) ? S_DBG_HALT : S_RUN;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (dbg_halt_req_in || state_q == S_DBG_DRAIN) ? S_DBG_DRAIN : S_STALL_MD;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = (pend_q || dbg_halt_req_in) ? S_DBG_HALT : S_RUN;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    pend_d = pend_q | dbg_halt_req_in;
                end
            end
            S_DBG_HALT: begin
                if (dbg_resume_in && !dbg_halt_req_in) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hctl_clock_in) begin
        if (hctl_reset_in) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            halt_q  <= 1'b0;
            flush_q <= 1'b0;
            dbg_q   <= 1'b0;
            cause_q <= 3'd0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            halt_q  <= (state_d == S_STALL_LU) || (state_d == S_STALL_MD) ||
                       (state_d == S_DBG_DRAIN) || (state_d == S_DBG_HALT);
            flush_q <= (state_d == S_FLUSH);
            dbg_q   <= (state_d == S_DBG_HALT);
            cause_q <= state_d;
            if (halt_q && count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign halt_signal_out = halt_q;
    assign flush_out       = flush_q;
    assign dbg_halted_out  = dbg_q;
    assign stall_cause_out = cause_q;
    assign stall_count_out = count_q;

endmodule

// File: tb/tb_hazard_halt_control.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs, which are
// queued at drive time and compared one cycle later against the DUT.
module tb_hazard_halt_control;

    localparam int MD_CYCLES    = 8;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;

    logic        clk = 1'b0;
    logic        rst, lu, md, br, req, res;
    logic        halt, flush, dbgh;
    logic [2:0]  cause;
    logic [15:0] scount;

    typedef struct packed {
        logic        halt;
        logic        flush;
        logic        dbgh;
        logic [2:0]  cause;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // model: state 0 run,1 lu,2 md,3 flush,4 drain,5 dbg halt; rem = cycles left
    int          m_st = 0;
    int          m_rem = 0;
    bit          m_pend = 0;
    logic [15:0] m_cnt = 16'd0;

    hazard_halt_control #(
        .MD_CYCLES(MD_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .hctl_clock_in(clk),
        .hctl_reset_in(rst),
        .load_use_in(lu),
        .md_start_in(md),
        .branch_taken_in(br),
        .dbg_halt_req_in(req),
        .dbg_resume_in(res),
        .halt_signal_out(halt),
        .flush_out(flush),
        .dbg_halted_out(dbgh),
        .stall_cause_out(cause),
        .stall_count_out(scount)
    );

    always #5 clk = ~clk;

    function automatic bit m_halt(input int st);
        return (st == 1) || (st == 2) || (st == 4) || (st == 5);
    endfunction

    task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got h=%b f=%b d=%b c=%0d n=%0d, expected h=%b f=%b d=%b c=%0d n=%0d",
                     tag, got[21], got[20], got[19], got[18:16], got[15:0],
                     exp[21], exp[20], exp[19], exp[18:16], exp[15:0]);
        end
    endtask

    task automatic model_step();
        int          st_n;
        logic [15:0] cnt_n;
        st_n  = m_st;
        cnt_n = (m_halt(m_st) && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
        case (m_st)
            0: begin
                if (req) st_n = 5;
                else if (br) begin st_n = 3; m_rem = FLUSH_CYCLES; end
                else if (md) begin st_n = 2; m_rem = MD_CYCLES; end
                else if (lu) st_n = 1;
            end
            1: st_n = req ? 5 : 0;
            2, 4: begin
                if (m_rem == 1) st_n = (req || m_st == 4) ? 5 : 0;
                else begin
                    m_rem--;
                    st_n = (req || m_st == 4) ? 4 : 2;
                end
            end
            3: begin
                if (m_rem == 1) begin
                    st_n   = (m_pend || req) ? 5 : 0;
                    m_pend = 0;
                end else begin
                    m_rem--;
                    m_pend = m_pend | req;
                end
            end
            default: if (res && !req) st_n = 0;
        endcase
        if (rst) begin
            st_n   = 0;
            cnt_n  = 16'd0;
            m_pend = 0;
        end
        m_st  = st_n;
        m_cnt = cnt_n;
    endtask

    task automatic step(input string tag, input logic i_lu, input logic i_md, input logic i_br,
                        input logic i_req, input logic i_res, input logic i_rst);
        exp_t e;
        exp_t g;
        lu = i_lu; md = i_md; br = i_br; req = i_req; res = i_res; rst = i_rst;
        model_step();
        e.halt  = m_halt(m_st);
        e.flush = (m_st == 3);
        e.dbgh  = (m_st == 5);
        e.cause = 3'(m_st);
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = '{halt, flush, dbgh, cause, scount};
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, expected one entry", tag);
        end else begin
            check_eq(tag, g, sb.pop_front());
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        lu = 0; md = 0; br = 0; req = 0; res = 0; rst = 1;

        step("reset", 0, 0, 0, 0, 0, 1);
        step("reset", 0, 0, 0, 0, 0, 1);
        idle("idle", 5);

        step("lu_pulse", 1, 0, 0, 0, 0, 0);
        idle("lu_after", 3);

        step("md_pulse", 0, 1, 0, 0, 0, 0);
        idle("md_stall", 10);

        step("br_lu", 1, 0, 1, 0, 0, 0);
        step("flush_sq", 1, 1, 1, 0, 0, 0);
        idle("flush_after", 4);

        step("md_dbg", 0, 1, 0, 0, 0, 0);
        idle("md_dbg", 2);
        step("dbg_req", 0, 0, 0, 1, 0, 0);
        idle("drain", 7);
        step("resume_ign", 0, 0, 0, 0, 0, 0);
        step("resume", 0, 0, 0, 0, 1, 0);
        idle("post_resume", 2);

        step("md_last", 0, 1, 0, 0, 0, 0);
        idle("md_last", 6);
        step("req_last", 0, 0, 0, 1, 0, 0);
        idle("halted", 2);
        step("resume2", 0, 0, 0, 0, 1, 0);

        step("br_dbg", 0, 0, 1, 0, 0, 0);
        step("flush_req", 0, 0, 0, 1, 0, 0);
        idle("flush_pend", 2);
        step("req_res", 0, 0, 0, 1, 1, 0);
        step("req_res", 0, 0, 0, 1, 1, 0);
        step("res_only", 0, 0, 0, 0, 1, 0);

        step("run_prio", 1, 1, 1, 1, 0, 0);
        step("both", 0, 0, 0, 1, 1, 0);
        step("mid_reset", 0, 0, 0, 1, 0, 1);
        idle("post_reset", 2);
        step("res_outside", 0, 0, 0, 0, 1, 0);
        step("md_lu_prio", 1, 1, 0, 0, 0, 0);
        idle("md_lu_prio", 9);

        for (int i = 0; i < 400; i++) begin
            step("random",
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end

        step("sat_reset", 0, 0, 0, 0, 0, 1);
        step("sat_req", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 65540; i++) step("sat", 0, 0, 0, 0, 0, 0);
        step("sat_resume", 0, 0, 0, 0, 1, 0);
        idle("sat_hold", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
